io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per byte FIFO; power of two, minimum 2.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning cycle-counter width; fixed at 32 in this revision.
REQ-003 SHALL have port clk_in  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_in_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  bus-owner ready; low freezes all bus side effects and the counter.
REQ-006 SHALL have port io_en  input  1  IO window selected this cycle.
REQ-007 SHALL have port io_sel  input  3  register select.
REQ-008 SHALL have port io_wr  input  1  1=write, 0=read.
REQ-009 SHALL have port io_din  input  8  write data.
REQ-010 SHALL have port io_dout  output  8  registered read data.
REQ-011 SHALL have ports tx_data output 8, tx_valid output 1, tx_ready input 1: host-bound byte stream.
REQ-012 SHALL have ports rx_data input 8, rx_valid input 1, rx_ready output 1: host-supplied byte stream.
REQ-013 SHALL have port halt_out  output  1  sticky program-end flag.

Function
REQ-014 SHALL act on a bus access only in cycles where io_en=1 and rdy_in=1; any other cycle has no bus side effect.
REQ-015 SHALL return read data on io_dout one cycle after the access. io_dout holds its value until the next read.
REQ-016 SHALL implement this register map:
- sel0 write pushes io_din to TX FIFO.
- sel0 read pops RX FIFO; returns 0x00 and pops nothing if empty.
- sel1 read returns status {5'b0, tx_ovf, tx_full, rx_nonempty}.
- sel2..sel5 read return snapshot bytes 0..3, little-endian.
- sel4 write sets halt_out.
- All other accesses: reads return 0x00, writes are ignored.
REQ-017 SHALL load the snapshot from the live counter on a sel2 read; the sel2 read returns byte 0 of that new value.
REQ-018 SHALL increment the cycle counter every cycle that rdy_in=1, wrapping modulo 2^32.
REQ-019 SHALL present the TX FIFO head as tx_data with tx_valid=~tx_empty, and pop on tx_valid&tx_ready.
REQ-020 SHALL accept a TX push when not full, or when full and a pop occurs in the same cycle.
REQ-021 SHALL drop any other TX push and set sticky tx_ovf; a sel1 read clears tx_ovf after returning it.
REQ-022 SHALL drive rx_ready=~rx_full and push rx_data on rx_valid&rx_ready. A simultaneous bus pop of RX SHALL be allowed in the same cycle, with count unchanged.
REQ-023 SHALL use FIFO pointers log2(FIFO_DEPTH) bits wide that wrap at FIFO_DEPTH, plus a count of log2(FIFO_DEPTH)+1 bits.
REQ-024 SHALL keep halt_out set until reset; halt_out SHALL NOT block FIFO activity.

Reset
REQ-025 SHALL, while rst_in_n=0, asynchronously force:
- io_dout=0, halt_out=0, tx_ovf=0, counter=0, snapshot=0;
- all FIFO pointers and counts=0, giving tx_valid=0 and rx_ready=1.
REQ-026 SHALL discard FIFO contents on reset asserted mid-operation; after release, the first cycle behaves as after power-up.

Structure
REQ-027 SHALL take the register-select constants (IO_SEL_DATA=0, IO_SEL_STAT=1, IO_SEL_CNT0=2, IO_SEL_HALT=4) and the status bit positions from the shared package io_pkg.
REQ-028 SHALL instantiate two copies of one sub-module, byte_fifo (parameter DEPTH; push/pop/full/empty/head), one for TX and one for RX.

Verification
REQ-029 SHALL cover TX path: write sel0 with 0x41, 0x42 while tx_ready=0, then raise tx_ready -> tx_data 0x41 then 0x42, then tx_valid=0.
REQ-030 SHALL cover TX overflow: 17 writes to sel0 with tx_ready=0 -> 16 bytes held; sel1 read returns 0x06; a second sel1 read returns 0x02.
REQ-031 SHALL cover RX path: host pushes 0x55, then bus reads sel0 twice -> io_dout 0x55 then 0x00; status bit0 goes 1 then 0.
REQ-032 SHALL cover counter: reset, hold rdy_in=1 for 300 cycles, read sel2..sel5 -> bytes form the value latched at the sel2 read (≈300); reads of sel3..5 do not re-latch.
REQ-033 SHALL cover gating: sel0 write with rdy_in=0 -> no push; write sel4 -> halt_out=1 next cycle and held until rst_in_n pulse.
REQ-034 SHALL cover reset mid-stream: assert rst_in_n=0 with both FIFOs non-empty -> tx_valid=0, rx_ready=1, io_dout=0 immediately.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared register-map and status-layout definitions for io_responder.
//   IO_SEL_*    : 3-bit register select values seen on io_sel.
//   STAT_*      : bit positions inside the sel1 status byte.
//   pack_status : builds the status byte from its three flags.
package io_pkg;

  localparam logic [2:0] IO_SEL_DATA = 3'd0;  // write: push TX, read: pop RX
  localparam logic [2:0] IO_SEL_STAT = 3'd1;  // read: status byte
  localparam logic [2:0] IO_SEL_CNT0 = 3'd2;  // read: latch snapshot, return byte 0
  localparam logic [2:0] IO_SEL_CNT1 = 3'd3;  // read: snapshot byte 1
  localparam logic [2:0] IO_SEL_CNT2 = 3'd4;  // read: snapshot byte 2
  localparam logic [2:0] IO_SEL_CNT3 = 3'd5;  // read: snapshot byte 3
  localparam logic [2:0] IO_SEL_HALT = 3'd4;  // write: set halt_out

  localparam int STAT_RX_NONEMPTY = 0;
  localparam int STAT_TX_FULL     = 1;
  localparam int STAT_TX_OVF      = 2;

  function automatic logic [7:0] pack_status(input logic tx_ovf,
                                             input logic tx_full,
                                             input logic rx_nonempty);
    logic [7:0] s;
    s                   = 8'h00;
    s[STAT_TX_OVF]      = tx_ovf;
    s[STAT_TX_FULL]     = tx_full;
    s[STAT_RX_NONEMPTY] = rx_nonempty;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: single-clock byte FIFO, DEPTH entries (power of two, >= 2).
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push, din  : write request and data; taken when not full, or when full
//                and a pop happens in the same cycle
//   pop        : read request; ignored while empty
//   head       : oldest entry (valid while empty=0)
//   full/empty : occupancy flags derived from the count
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs, so full+pop still accepts.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_responder.sv
// io_responder: small IO-window peripheral: byte streams to/from a host,
// a free-running cycle counter with a latched snapshot, and a halt flag.
//   clk_in, rst_in_n         : clock, asynchronous active-low reset
//   rdy_in                   : bus-owner ready; low freezes bus effects and counter
//   io_en/io_sel/io_wr/io_din: bus access (acts only when io_en & rdy_in)
//   io_dout                  : read data, registered, held until the next read
//   tx_data/tx_valid/tx_ready: host-bound byte stream (TX FIFO head)
//   rx_data/rx_valid/rx_ready: host-supplied byte stream (into RX FIFO)
//   halt_out                 : sticky, set by a sel4 write, cleared by reset
//
// Stream handshakes: a byte moves on a rising edge where valid & ready are
// both high; the source holds data stable while valid is high and not taken,
// and ready never depends combinationally on valid.
module io_responder
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32   // byte slicing below assumes 32
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rdy_in,
  input  logic       io_en,
  input  logic [2:0] io_sel,
  input  logic       io_wr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       halt_out
);

  logic                 bus_rd;
  logic                 bus_wr;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_drop;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_full;
  logic                 rx_empty;
  logic [7:0]           rx_head;
  logic                 tx_ovf;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] snapshot;
  logic [7:0]           rd_byte;

  assign bus_rd  = io_en & rdy_in & ~io_wr;
  assign bus_wr  = io_en & rdy_in & io_wr;

  assign tx_push = bus_wr & (io_sel == IO_SEL_DATA);
  assign tx_pop  = tx_valid & tx_ready;
  // Same acceptance rule as byte_fifo: dropped only if full with no pop.
  assign tx_drop = tx_push & tx_full & ~tx_pop;
  assign tx_valid = ~tx_empty;

  assign rx_pop   = bus_rd & (io_sel == IO_SEL_DATA);
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (io_din),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Read mux. The sel2 read returns the live counter's low byte, which is
  // exactly byte 0 of the snapshot being loaded in the same cycle.
  always_comb begin
    rd_byte = 8'h00;
    case (io_sel)
      IO_SEL_DATA: rd_byte = rx_empty ? 8'h00 : rx_head;
      IO_SEL_STAT: rd_byte = pack_status(tx_ovf, tx_full, ~rx_empty);
      IO_SEL_CNT0: rd_byte = cycle_cnt[7:0];
      IO_SEL_CNT1: rd_byte = snapshot[15:8];
      IO_SEL_CNT2: rd_byte = snapshot[23:16];
      IO_SEL_CNT3: rd_byte = snapshot[31:24];
      default:     rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      io_dout   <= 8'h00;
      halt_out  <= 1'b0;
      tx_ovf    <= 1'b0;
      cycle_cnt <= '0;
      snapshot  <= '0;
    end else begin
      if (rdy_in) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (bus_rd) io_dout <= rd_byte;
      if (bus_rd && io_sel == IO_SEL_CNT0) snapshot <= cycle_cnt;
      if (bus_wr && io_sel == IO_SEL_HALT) halt_out <= 1'b1;
      // A drop needs a write and a clear needs a read, so they never collide.
      if (tx_drop)
        tx_ovf <= 1'b1;
      else if (bus_rd && io_sel == IO_SEL_STAT)
        tx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy_in;
  logic       io_en;
  logic [2:0] io_sel;
  logic       io_wr;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       halt_out;

  always #5 clk = ~clk;

  io_responder #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk_in   (clk),
    .rst_in_n (rst_n),
    .rdy_in   (rdy_in),
    .io_en    (io_en),
    .io_sel   (io_sel),
    .io_wr    (io_wr),
    .io_din   (io_din),
    .io_dout  (io_dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .halt_out (halt_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (scoreboard) ----------------
  logic [7:0]  exp_q[$];   // bytes expected on the TX stream, oldest first
  logic [7:0]  rx_q[$];    // bytes held on the RX side
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic        m_ovf;
  logic        m_halt;
  logic [7:0]  m_dout;

  task automatic model_reset();
    exp_q.delete();
    rx_q.delete();
    m_cnt  = 0;
    m_snap = 0;
    m_ovf  = 1'b0;
    m_halt = 1'b0;
    m_dout = 8'h00;
  endtask

  // Applies one rising edge worth of behaviour using the current inputs.
  task automatic model_edge();
    logic       act;
    logic       rx_take;
    logic [7:0] stat;
    act     = io_en && rdy_in;
    rx_take = rx_valid && (rx_q.size() < DEPTH);
    stat    = {5'b0, m_ovf, exp_q.size() == DEPTH, rx_q.size() != 0};
    if (tx_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (act && io_wr) begin
      if (io_sel == 3'd0) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(io_din);
        else m_ovf = 1'b1;
      end
      if (io_sel == 3'd4) m_halt = 1'b1;
    end
    if (act && !io_wr) begin
      if (io_sel == 3'd0) begin
        if (rx_q.size() != 0) m_dout = rx_q.pop_front();
        else m_dout = 8'h00;
      end else if (io_sel == 3'd1) begin
        m_dout = stat;
        m_ovf  = 1'b0;
      end else if (io_sel >= 3'd2 && io_sel <= 3'd5) begin
        if (io_sel == 3'd2) m_snap = m_cnt;
        m_dout = 8'((m_snap >> (8 * (int'(io_sel) - 2))) & 32'hFF);
      end else begin
        m_dout = 8'h00;
      end
    end
    if (rx_take) rx_q.push_back(rx_data);
    if (rdy_in) m_cnt = m_cnt + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rdy_in   = 1'b1;
    io_en    = 1'b0;
    io_sel   = 3'd0;
    io_wr    = 1'b0;
    io_din   = 8'h00;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
  endtask

  // One clock: advance the model, pass the edge, compare all outputs.
  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    check("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q[0]));
    check("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
    check("io_dout", 32'(io_dout), 32'(m_dout));
    check("halt_out", 32'(halt_out), 32'(m_halt));
  endtask

  task automatic bus_rd(input logic [2:0] sel);
    io_en = 1'b1; io_wr = 1'b0; io_sel = sel;
    tick();
    io_en = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] sel, input logic [7:0] d);
    io_en = 1'b1; io_wr = 1'b1; io_sel = sel; io_din = d;
    tick();
    io_en = 1'b0; io_wr = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       en;
    logic       rdy;
    logic [2:0] sel;
    logic       wr;
    logic [7:0] din;
    logic       txr;
    logic       rxv;
    logic [7:0] rxd;
    logic [7:0] e_dout;
    logic       e_txv;
    logic [7:0] e_txd;
    logic       e_rxr;
    logic       e_halt;
  } vec_t;

  vec_t vecs[20];

  initial begin
    //          en rdy sel wr din    txr rxv rxd      dout   txv txd    rxr halt
    vecs[0]  = '{1, 1, 0, 1, 8'h41, 0, 0, 8'h00, 8'h00, 1, 8'h41, 1, 0};
    vecs[1]  = '{1, 1, 0, 1, 8'h42, 0, 0, 8'h00, 8'h00, 1, 8'h41, 1, 0};
    vecs[2]  = '{0, 1, 0, 0, 8'h00, 0, 1, 8'h55, 8'h00, 1, 8'h41, 1, 0};
    vecs[3]  = '{1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 8'h41, 1, 0};
    vecs[4]  = '{0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 8'h41, 1, 0};
    vecs[5]  = '{1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 8'h41, 1, 0};
    vecs[6]  = '{1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h55, 1, 8'h41, 1, 0};
    vecs[7]  = '{1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h41, 1, 0};
    vecs[8]  = '{0, 1, 0, 0, 8'h00, 0, 1, 8'hA5, 8'h00, 1, 8'h41, 1, 0};
    vecs[9]  = '{1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 8'h41, 1, 0};
    vecs[10] = '{1, 1, 7, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h41, 1, 0};
    vecs[11] = '{1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 1, 8'h41, 1, 0};
    vecs[12] = '{1, 1, 1, 1, 8'hFF, 0, 0, 8'h00, 8'hA5, 1, 8'h41, 1, 0};
    vecs[13] = '{1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h41, 1, 0};
    vecs[14] = '{0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 8'h42, 1, 0};
    vecs[15] = '{0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0};
    vecs[16] = '{1, 0, 4, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0};
    vecs[17] = '{1, 0, 0, 1, 8'h77, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0};
    vecs[18] = '{1, 1, 4, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1};
    vecs[19] = '{1, 1, 6, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1};
  end

  // ---------------- test sequence ----------------
  initial begin
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    do_reset();

    check("reset_dout", 32'(io_dout), 32'h00);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_rx_ready", 32'(rx_ready), 32'h1);
    check("reset_halt", 32'(halt_out), 32'h0);

    // Register map, gating and TX/RX basics.
    for (int i = 0; i < 20; i++) begin
      io_en = vecs[i].en;   rdy_in = vecs[i].rdy; io_sel = vecs[i].sel;
      io_wr = vecs[i].wr;   io_din = vecs[i].din; tx_ready = vecs[i].txr;
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      tick();
      check($sformatf("vec%0d_dout", i), 32'(io_dout), 32'(vecs[i].e_dout));
      check($sformatf("vec%0d_txv", i), 32'(tx_valid), 32'(vecs[i].e_txv));
      if (vecs[i].e_txv) check($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(vecs[i].e_txd));
      check($sformatf("vec%0d_rxr", i), 32'(rx_ready), 32'(vecs[i].e_rxr));
      check($sformatf("vec%0d_halt", i), 32'(halt_out), 32'(vecs[i].e_halt));
    end
    set_idle();

    // halt_out stays set; FIFO activity continues while halted.
    repeat (10) tick();
    check("halt_held", 32'(halt_out), 32'h1);

    // Reset mid-stream with RX full and TX non-empty.
    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'($urandom);
      tick();
    end
    rx_valid = 1'b0;
    check("rx_full_ready", 32'(rx_ready), 32'h0);
    bus_wr(3'd0, 8'hC3);
    bus_wr(3'd0, 8'h3C);
    bus_rd(3'd1);
    check("pre_reset_status", 32'(io_dout), 32'h01);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("async_rst_rx_ready", 32'(rx_ready), 32'h1);
    check("async_rst_dout", 32'(io_dout), 32'h00);
    check("async_rst_halt", 32'(halt_out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_rd(3'd0);
    check("post_reset_rx_read", 32'(io_dout), 32'h00);
    check("post_reset_tx_valid", 32'(tx_valid), 32'h0);

    // TX overflow: 17 writes while the host is stalled.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) bus_wr(3'd0, 8'(i + 1));
    bus_rd(3'd1);
    check("ovf_status_1", 32'(io_dout), 32'h06);
    bus_rd(3'd1);
    check("ovf_status_2", 32'(io_dout), 32'h02);
    check("ovf_head", 32'(tx_data), 32'h01);
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (i < DEPTH - 1) check("ovf_drain_data", 32'(tx_data), 32'(i + 2));
      else check("ovf_drain_empty", 32'(tx_valid), 32'h0);
    end
    tx_ready = 1'b0;

    // Push into a full TX FIFO while the host pops in the same cycle.
    for (int i = 0; i < DEPTH; i++) bus_wr(3'd0, 8'(8'h80 + i));
    tx_ready = 1'b1;
    bus_wr(3'd0, 8'hEE);
    tx_ready = 1'b0;
    bus_rd(3'd1);
    check("full_pop_push_status", 32'(io_dout), 32'h02);

    // Counter snapshot: 300 cycles after reset.
    do_reset();
    repeat (300) tick();
    bus_rd(3'd2);
    check("cnt_byte0", 32'(io_dout), 32'h2C);
    bus_rd(3'd3);
    check("cnt_byte1", 32'(io_dout), 32'h01);
    bus_rd(3'd4);
    check("cnt_byte2", 32'(io_dout), 32'h00);
    bus_rd(3'd5);
    check("cnt_byte3", 32'(io_dout), 32'h00);
    repeat (300) tick();
    bus_rd(3'd3);
    check("cnt_no_relatch", 32'(io_dout), 32'h01);
    bus_rd(3'd2);
    check("cnt_relatch", 32'(io_dout), 32'h5D);

    // Randomized traffic against the model.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 500; c++) begin
        rdy_in   = ($urandom_range(0, 7) != 0);
        io_en    = 1'($urandom_range(0, 1));
        io_sel   = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 7));
        io_wr    = 1'($urandom_range(0, 1));
        io_din   = 8'($urandom);
        tx_ready = (blk % 2 == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) != 0);
        rx_valid = (blk % 2 == 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 15) == 0);
        rx_data  = 8'($urandom);
        tick();
      end
    end
    set_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
